tcam_7x64_ctrl: RTL



---
 rtl/tcam_ctrl_pkg.sv | 36 +++
 rtl/tcam_prio_enc.sv | 19 +
 rtl/tcam_7x64_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tcam_ctrl_pkg.sv
// Shared types and constants for the 7-bit-key, 64-entry TCAM sequencer.
// Holds request ops, FSM states and the ternary row-encoding rule.
package tcam_ctrl_pkg;

  localparam int KEY_W   = 7;
  localparam int ENTRY_W = 6;
  localparam int ROWS    = 1 << KEY_W;

  typedef enum logic [1:0] {
    OP_SRCH = 2'b00,
    OP_WR   = 2'b01,
    OP_DEL  = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SRCH_RD,
    ST_SRCH_WAIT,
    ST_SRCH_RSP,
    ST_UPD_RD,
    ST_UPD_WAIT,
    ST_UPD_WR,
    ST_UPD_DONE,
    ST_ERR_RSP
  } state_e;

  function automatic logic row_bit(
    input logic [KEY_W-1:0] r,
    input logic [KEY_W-1:0] key,
    input logic [KEY_W-1:0] mask
  );
    return (r & ~mask) == (key & ~mask);
  endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// 64-bit lowest-index priority encoder for TCAM hit reporting.
// Lowest set bit wins; idx is 0 when nothing is set.
module tcam_prio_enc
  import tcam_ctrl_pkg::*;
(
  input  logic [63:0]        in_vec,
  output logic               out_hit,
  output logic [ENTRY_W-1:0] out_idx
);

  always_comb begin
    out_hit = |in_vec;
    out_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (in_vec[i]) out_idx = ENTRY_W'(i);
    end
  end

endmodule

// File: rtl/tcam_7x64_ctrl.sv
// Request sequencer for the SRAM-based 7x64 TCAM (search, rule RMW, delete).
// Define TCAM_CTRL_PRIO_ENC_EN to return hit/lowest index with each search.
module tcam_7x64_ctrl
  import tcam_ctrl_pkg::*;
(
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_req_valid,
  output logic               out_req_ready,
  input  logic [1:0]         in_req_op,
  input  logic [KEY_W-1:0]   in_req_key,
  input  logic [KEY_W-1:0]   in_req_mask,
  input  logic [ENTRY_W-1:0] in_req_entry,
  output logic               out_rsp_valid,
  output logic [63:0]        out_rsp_match,
  output logic               out_rsp_hit,
  output logic [ENTRY_W-1:0] out_rsp_idx,
  output logic               out_rsp_err,
  output logic               out_busy,
  output logic               out_mem_csb,
  output logic               out_mem_web,
  output logic [3:0]         out_mem_wmask,
  output logic [7:0]         out_mem_addr,
  output logic [31:0]        out_mem_wdata,
  input  logic [63:0]        in_mem_rdata
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [KEY_W-1:0]   mask_q, mask_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [KEY_W-1:0]   row_q, row_d;
  logic [31:0]        word_q, word_d;
  logic [63:0]        match_q, match_d;
  logic               rule_bit;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SRCH;
      key_q   <= '0;
      mask_q  <= '0;
      entry_q <= '0;
      row_q   <= '0;
      word_q  <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      entry_q <= entry_d;
      row_q   <= row_d;
      word_q  <= word_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    mask_d  = mask_q;
    entry_d = entry_q;
    row_d   = row_q;
    word_d  = word_q;
    match_d = match_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_req_valid) begin
          op_d    = op_e'(in_req_op);
          key_d   = in_req_key;
          mask_d  = in_req_mask;
          entry_d = in_req_entry;
          row_d   = '0;
          unique case (op_e'(in_req_op))
            OP_SRCH: state_d = ST_SRCH_RD;
            OP_WR:   state_d = ST_UPD_RD;
            OP_DEL:  state_d = ST_UPD_RD;
            default: state_d = ST_ERR_RSP;
          endcase
        end
      end
      ST_SRCH_RD:  state_d = ST_SRCH_WAIT;
      ST_SRCH_WAIT: begin
        match_d = in_mem_rdata;
        state_d = ST_SRCH_RSP;
      end
      ST_UPD_RD:   state_d = ST_UPD_WAIT;
      ST_UPD_WAIT: begin
        word_d  = entry_q[5] ? in_mem_rdata[63:32]
                             : in_mem_rdata[31:0];
        state_d = ST_UPD_WR;
      end
      ST_UPD_WR: begin
        if (row_q == KEY_W'(ROWS - 1)) begin
          state_d = ST_UPD_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ST_UPD_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delete shares the RMW path; it just writes a constant 0 rule bit.
  assign rule_bit = (op_q == OP_WR) &&
                    row_bit(row_q, key_q, mask_q);

  always_comb begin
    out_req_ready = 1'b0;
    out_rsp_valid = 1'b0;
    out_rsp_match = '0;
    out_rsp_err   = 1'b0;
    out_mem_csb   = 1'b1;
    out_mem_web   = 1'b1;
    out_mem_wmask = '0;
    out_mem_addr  = '0;
    out_mem_wdata = '0;
    unique case (state_q)
      ST_IDLE: out_req_ready = 1'b1;
      ST_SRCH_RD: begin
        out_mem_csb  = 1'b0;
        out_mem_addr = {1'b0, key_q};
      end
      ST_SRCH_RSP: begin
        out_rsp_valid = 1'b1;
        out_rsp_match = match_q;
      end
      ST_UPD_RD: begin
        out_mem_csb  = 1'b0;
        out_mem_addr = {entry_q[5], row_q};
      end
      ST_UPD_WR: begin
        out_mem_csb   = 1'b0;
        out_mem_web   = 1'b0;
        out_mem_addr  = {entry_q[5], row_q};
        out_mem_wmask = 4'b0001 << entry_q[4:3];
        out_mem_wdata = word_q;
        out_mem_wdata[entry_q[4:0]] = rule_bit;
      end
      ST_UPD_DONE: out_rsp_valid = 1'b1;
      ST_ERR_RSP: begin
        out_rsp_valid = 1'b1;
        out_rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_busy = (state_q != ST_IDLE);

`ifdef TCAM_CTRL_PRIO_ENC_EN
  tcam_prio_enc u_prio_enc (
    .in_vec  (out_rsp_match),
    .out_hit (out_rsp_hit),
    .out_idx (out_rsp_idx)
  );
`else
  assign out_rsp_hit = 1'b0;
  assign out_rsp_idx = '0;
`endif

endmodule
